// File: rtl/axis_rr_packet_mux_pkg.sv
// rtl/axis_rr_packet_mux_pkg.sv - shared FSM encoding and one-hot index helper
package axis_rr_packet_mux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam int MAX_REQ   = 32;
  localparam int ENC_WIDTH = 5;

  // Binary index of the set bit; callers zero-extend narrower one-hot vectors.
  function automatic logic [ENC_WIDTH-1:0] onehot_to_bin(input logic [MAX_REQ-1:0] onehot);
    logic [ENC_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) idx = idx | ENC_WIDTH'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/axis_rr_packet_mux_if.sv
// rtl/axis_rr_packet_mux_if.sv - upstream and downstream stream bundle for the packet mux
interface axis_rr_packet_mux_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_REQ-1:0]            s_axis_tvalid;
  logic [NUM_REQ-1:0]            s_axis_tlast;
  logic [NUM_REQ-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic                          m_axis_tvalid;
  logic                          m_axis_tlast;
  logic [ID_WIDTH-1:0]           m_axis_tid;
  logic                          m_axis_tready;

  // master: the mux, which drives the shared egress stream
  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid,
    input  m_axis_tready
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid,
    output m_axis_tready
  );
endinterface

// File: rtl/axis_rr_packet_mux_rr_base_grant.sv
// rtl/axis_rr_packet_mux_rr_base_grant.sv - rotating-priority grant starting at the base bit
module rr_base_grant #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] base,
  input  logic [NUM_REQ-1:0] request,
  output logic [NUM_REQ-1:0] grant
);
  logic [2*NUM_REQ-1:0] double_req;
  logic [2*NUM_REQ-1:0] masked;

  // Borrow from the subtraction stops at the first request at or above base, wrapping via the upper copy.
  assign double_req = {request, request};
  assign masked     = double_req & ~(double_req - {{NUM_REQ{1'b0}}, base});
  assign grant      = masked[NUM_REQ-1:0] | masked[2*NUM_REQ-1:NUM_REQ];
endmodule

// File: rtl/axis_rr_packet_mux.sv
// rtl/axis_rr_packet_mux.sv - round-robin packet-locked stream mux with registered output slice
module axis_rr_packet_mux
  import axis_rr_packet_mux_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arb_enable,
  axis_rr_packet_mux_if.master axis,
  output logic [NUM_REQ-1:0]   cur_grant,
  output logic                 busy
);
  state_t                  state;
  logic [NUM_REQ-1:0]      ptr;
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ-1:0]      rr_grant;
  logic [ENC_WIDTH-1:0]    grant_idx;
  logic [ID_WIDTH-1:0]     tid_q;
  logic                    out_ready;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   beat_data;
  logic                    beat_last;

  // With arbitration disabled only port 0 may compete.
  assign req       = arb_enable ? axis.s_axis_tvalid
                                : {{(NUM_REQ-1){1'b0}}, axis.s_axis_tvalid[0]};
  assign out_ready = ~axis.m_axis_tvalid | axis.m_axis_tready;
  assign axis.s_axis_tready = (state == ST_LOCK && out_ready) ? cur_grant : '0;
  assign accept    = |(axis.s_axis_tvalid & axis.s_axis_tready);
  assign busy      = (state == ST_LOCK);
  assign grant_idx = onehot_to_bin(MAX_REQ'(rr_grant));

  rr_base_grant #(.NUM_REQ(NUM_REQ)) u_rr_base_grant (
    .base    (ptr),
    .request (req),
    .grant   (rr_grant)
  );

  always_comb begin
    beat_data = '0;
    beat_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cur_grant[i]) begin
        beat_data = beat_data | axis.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        beat_last = beat_last | axis.s_axis_tlast[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= ST_IDLE;
      ptr                <= NUM_REQ'(1);
      cur_grant          <= '0;
      tid_q              <= '0;
      axis.m_axis_tdata  <= '0;
      axis.m_axis_tvalid <= 1'b0;
      axis.m_axis_tlast  <= 1'b0;
      axis.m_axis_tid    <= '0;
    end else begin
      // A load below overrides this drain, giving take-and-load in the same cycle.
      if (axis.m_axis_tvalid && axis.m_axis_tready) axis.m_axis_tvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            cur_grant <= rr_grant;
            tid_q     <= ID_WIDTH'(grant_idx);
            state     <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (accept) begin
            axis.m_axis_tdata  <= beat_data;
            axis.m_axis_tlast  <= beat_last;
            axis.m_axis_tid    <= tid_q;
            axis.m_axis_tvalid <= 1'b1;
            if (beat_last) begin
              state     <= ST_IDLE;
              cur_grant <= '0;
              if (arb_enable) ptr <= {cur_grant[NUM_REQ-2:0], cur_grant[NUM_REQ-1]};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_rr_packet_mux.sv
// tb/tb_axis_rr_packet_mux.sv - self-checking bench for the round-robin packet mux
module tb_axis_rr_packet_mux;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int IW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [IW-1:0] tid;
  } beat_t;

  typedef struct {
    int           prev;
    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] grant;
  } arb_vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         arb_enable;
  logic [N-1:0] cur_grant;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  beat_t    obs_q[$];
  beat_t    exp_q[$];
  beat_t    mon_beat;
  beat_t    src_q[N][$];
  int       len_q[N][$];
  arb_vec_t tbl[9];

  axis_rr_packet_mux_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axis_rr_packet_mux #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .arb_enable (arb_enable),
    .axis       (bus.master),
    .cur_grant  (cur_grant),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Beats presented at the negedge with valid & ready are taken at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.m_axis_tvalid && bus.m_axis_tready) begin
      mon_beat.data = bus.m_axis_tdata;
      mon_beat.last = bus.m_axis_tlast;
      mon_beat.tid  = bus.m_axis_tid;
      obs_q.push_back(mon_beat);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: actual=timeout expected=completion", name);
  endtask

  task automatic idle_inputs();
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
    bus.m_axis_tready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    arb_enable = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic push_exp(input logic [DW-1:0] data, input logic last, input int tid);
    beat_t b;
    b.data = data;
    b.last = last;
    b.tid  = IW'(tid);
    exp_q.push_back(b);
  endtask

  task automatic send_pkt(input int p, input int len, input logic [DW-1:0] base);
    int  n;
    bit  got;
    for (int b = 0; b < len; b++) begin
      bus.s_axis_tdata[p*DW +: DW] = base + DW'(b);
      bus.s_axis_tvalid[p] = 1'b1;
      bus.s_axis_tlast[p]  = (b == len - 1);
      n = 0;
      got = 1'b0;
      while (!got && n < 50) begin
        settle();
        got = bus.s_axis_tvalid[p] & bus.s_axis_tready[p];
        tick();
        n++;
      end
      if (!got) fail_now("send_pkt");
    end
    bus.s_axis_tvalid[p] = 1'b0;
    bus.s_axis_tlast[p]  = 1'b0;
  endtask

  task automatic compare_obs(input string name);
    check({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({name, "_data"}, obs_q[i].data, exp_q[i].data);
      check({name, "_last"}, 64'(obs_q[i].last), 64'(exp_q[i].last));
      check({name, "_tid"},  64'(obs_q[i].tid),  64'(exp_q[i].tid));
    end
  endtask

  // Expected order: every port with packets left requests in IDLE, so service is strict rotation.
  task automatic run_stream(input int npk, input bit rnd, input string name);
    int    sidx[N];
    int    inpk[N];
    int    rem[N];
    int    pk[N];
    int    bpos[N];
    int    starts[$];
    int    exp_len[$];
    int    last_p, cyc, len, q;
    bit    done, picked;
    logic  [N-1:0] vld;
    beat_t bt;
    do_reset();
    for (int p = 0; p < N; p++) begin
      src_q[p].delete();
      len_q[p].delete();
      sidx[p] = 0; inpk[p] = 0; rem[p] = npk; pk[p] = 0; bpos[p] = 0;
      for (int k = 0; k < npk; k++) begin
        len = rnd ? int'($urandom_range(1, 4)) : 2;
        len_q[p].push_back(len);
        for (int b = 0; b < len; b++) begin
          bt.data = {$urandom(), $urandom()};
          bt.last = (b == len - 1);
          bt.tid  = IW'(p);
          src_q[p].push_back(bt);
        end
      end
    end
    last_p = N - 1;
    for (int n = 0; n < N * npk; n++) begin
      picked = 1'b0;
      for (int off = 1; off <= N && !picked; off++) begin
        q = (last_p + off) % N;
        if (rem[q] > 0) begin
          for (int b = 0; b < len_q[q][pk[q]]; b++) begin
            exp_q.push_back(src_q[q][bpos[q]]);
            bpos[q]++;
          end
          exp_len.push_back(len_q[q][pk[q]]);
          pk[q]++;
          rem[q]--;
          last_p = q;
          picked = 1'b1;
        end
      end
    end
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 4000) begin
      done = (obs_q.size() >= exp_q.size());
      for (int p = 0; p < N; p++) begin
        if (sidx[p] < src_q[p].size()) begin
          done = 1'b0;
          bus.s_axis_tdata[p*DW +: DW] = src_q[p][sidx[p]].data;
          bus.s_axis_tlast[p] = src_q[p][sidx[p]].last;
          vld[p] = (rnd && inpk[p] > 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
        end else begin
          bus.s_axis_tlast[p] = 1'b0;
          vld[p] = 1'b0;
        end
      end
      if (!done) begin
        bus.s_axis_tvalid = vld;
        bus.m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        settle();
        check({name, "_ready_onehot"}, 64'($countones(bus.s_axis_tready) <= 1), 64'(1));
        for (int p = 0; p < N; p++) begin
          if (bus.s_axis_tvalid[p] && bus.s_axis_tready[p]) begin
            if (inpk[p] == 0) starts.push_back(cyc);
            inpk[p] = src_q[p][sidx[p]].last ? 0 : inpk[p] + 1;
            sidx[p]++;
          end
        end
        tick();
        cyc++;
      end
    end
    if (!done) fail_now({name, "_drain"});
    idle_inputs();
    compare_obs(name);
    if (!rnd) begin
      check({name, "_pkt_count"}, 64'(starts.size()), 64'(exp_len.size()));
      for (int k = 0; k + 1 < starts.size() && k < exp_len.size(); k++)
        check({name, "_gap"}, 64'(starts[k+1] - starts[k]), 64'(exp_len[k] + 1));
    end
  endtask

  initial begin
    int   b, c, k0, b3, acc, exp_idx;
    bit   seen;
    logic pat[4];

    rst = 1'b1;
    arb_enable = 1'b1;
    idle_inputs();

    // Reset state and idle behaviour
    repeat (2) tick();
    check("rst_out", {62'd0, bus.m_axis_tvalid, bus.m_axis_tlast}, 64'd0);
    check("rst_misc", {55'd0, cur_grant, busy, bus.s_axis_tready}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_data", bus.m_axis_tdata, 64'd0);
      check("idle_ctrl", {53'd0, bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tid,
                          cur_grant, busy, bus.s_axis_tready}, 64'd0);
    end

    // Arbitration vectors: prev = port served first to set the pointer (-1 = none)
    tbl[0] = '{-1, 1'b1, 4'b1111, 4'b0001};
    tbl[1] = '{ 1, 1'b1, 4'b0011, 4'b0001};
    tbl[2] = '{ 1, 1'b1, 4'b1100, 4'b0100};
    tbl[3] = '{ 3, 1'b1, 4'b1010, 4'b0010};
    tbl[4] = '{ 2, 1'b1, 4'b0111, 4'b0001};
    tbl[5] = '{ 2, 1'b0, 4'b1110, 4'b0000};
    tbl[6] = '{ 2, 1'b0, 4'b1111, 4'b0001};
    tbl[7] = '{ 0, 1'b1, 4'b1001, 4'b1000};
    tbl[8] = '{-1, 1'b1, 4'b0110, 4'b0010};
    for (int r = 0; r < 9; r++) begin
      do_reset();
      if (tbl[r].prev >= 0) send_pkt(tbl[r].prev, 1, 64'hA0);
      arb_enable = tbl[r].en;
      for (int p = 0; p < N; p++) bus.s_axis_tdata[p*DW +: DW] = 64'h1000 + DW'(p);
      bus.s_axis_tvalid = tbl[r].req;
      bus.s_axis_tlast  = tbl[r].req;
      tick();
      settle();
      check("tbl_grant", 64'(cur_grant), 64'(tbl[r].grant));
      check("tbl_busy", 64'(busy), 64'(tbl[r].grant != 0));
      if (tbl[r].grant != 0) begin
        exp_idx = 0;
        for (int p = 0; p < N; p++) if (tbl[r].grant[p]) exp_idx = p;
        tick();
        check("tbl_out_valid", 64'(bus.m_axis_tvalid), 64'd1);
        check("tbl_out_tid", 64'(bus.m_axis_tid), 64'(exp_idx));
        check("tbl_out_data", bus.m_axis_tdata, 64'h1000 + 64'(exp_idx));
      end
      idle_inputs();
    end

    // Single source: port 2, three beats, full-rate output
    do_reset();
    bus.s_axis_tdata[2*DW +: DW] = 64'hD0;
    bus.s_axis_tvalid[2] = 1'b1;
    settle();
    check("t2_idle_ready", 64'(bus.s_axis_tready), 64'd0);
    tick();
    check("t2_grant", 64'(cur_grant), 64'b0100);
    check("t2_no_out_yet", 64'(bus.m_axis_tvalid), 64'd0);
    check("t2_ready", 64'(bus.s_axis_tready), 64'b0100);
    tick();
    bus.s_axis_tdata[2*DW +: DW] = 64'hD1;
    settle();
    check("t2_beat0", {bus.m_axis_tdata[59:0], bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tid},
          {60'hD0, 1'b1, 1'b0, 2'd2});
    tick();
    bus.s_axis_tdata[2*DW +: DW] = 64'hD2;
    bus.s_axis_tlast[2] = 1'b1;
    settle();
    check("t2_beat1", {bus.m_axis_tdata[59:0], bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tid},
          {60'hD1, 1'b1, 1'b0, 2'd2});
    tick();
    idle_inputs();
    settle();
    check("t2_beat2", {bus.m_axis_tdata[59:0], bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tid},
          {60'hD2, 1'b1, 1'b1, 2'd2});
    check("t2_released", {62'd0, |cur_grant, busy}, 64'd0);
    bus.s_axis_tvalid = 4'b1111;
    bus.s_axis_tlast  = 4'b1111;
    tick();
    check("t2_ptr_next", 64'(cur_grant), 64'b1000);
    idle_inputs();

    // Fairness with fixed two-beat packets
    run_stream(3, 1'b0, "fair");

    // Back-pressure on port 1
    do_reset();
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    b = 0;
    c = 0;
    while (obs_q.size() < 4 && c < 60) begin
      bus.m_axis_tready = pat[c % 4];
      bus.s_axis_tdata[1*DW +: DW] = 64'h4400 + DW'(b);
      bus.s_axis_tvalid[1] = (b < 4);
      bus.s_axis_tlast[1]  = (b == 3);
      settle();
      if (bus.m_axis_tvalid && !bus.m_axis_tready)
        check("bp_ready_low", 64'(bus.s_axis_tready[1]), 64'd0);
      if (bus.s_axis_tvalid[1] && bus.s_axis_tready[1]) b++;
      tick();
      c++;
    end
    if (c >= 60) fail_now("bp_drain");
    idle_inputs();
    tick();
    for (int i = 0; i < 4; i++) push_exp(64'h4400 + DW'(i), i == 3, 1);
    compare_obs("bp");

    // Lock held across arb_enable drop; afterwards only port 0 may be served
    do_reset();
    k0 = 0; b3 = 0; seen = 1'b0;
    for (int i = 0; i < 100 && k0 < 4; i++) begin
      if (b3 >= 2) arb_enable = 1'b0;
      bus.s_axis_tdata[3*DW +: DW] = (b3 < 4) ? 64'h300 + DW'(b3) : 64'h3FF;
      bus.s_axis_tvalid[3] = 1'b1;
      bus.s_axis_tlast[3]  = (b3 >= 3);
      if (b3 >= 2) begin
        bus.s_axis_tdata[0*DW +: DW] = 64'h100 + DW'(k0);
        bus.s_axis_tdata[1*DW +: DW] = 64'h1FF;
        bus.s_axis_tdata[2*DW +: DW] = 64'h2FF;
        bus.s_axis_tvalid[2:0] = 3'b111;
        bus.s_axis_tlast[2:0]  = 3'b111;
      end
      settle();
      if (b3 >= 1 && b3 < 4) check("lock_held", 64'(cur_grant), 64'b1000);
      if (b3 == 4) begin
        check("lock_no_high_grant", 64'(cur_grant & 4'b1110), 64'd0);
        if (!seen && cur_grant != 0) begin
          check("lock_next_grant", 64'(cur_grant), 64'b0001);
          seen = 1'b1;
        end
      end
      if (bus.s_axis_tvalid[3] && bus.s_axis_tready[3] && b3 < 4) b3++;
      if (bus.s_axis_tvalid[0] && bus.s_axis_tready[0]) k0++;
      tick();
    end
    if (!seen) fail_now("lock_port0_served");
    idle_inputs();
    arb_enable = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) push_exp(64'h300 + DW'(i), i == 3, 3);
    for (int i = 0; i < k0; i++) push_exp(64'h100 + DW'(i), 1'b1, 0);
    compare_obs("lock");

    // Asynchronous reset between beats of a five-beat packet
    do_reset();
    send_pkt(2, 1, 64'h77);
    acc = 0;
    c = 0;
    while (acc < 2 && c < 20) begin
      bus.s_axis_tdata[1*DW +: DW] = 64'h500 + DW'(acc);
      bus.s_axis_tvalid[1] = 1'b1;
      bus.s_axis_tlast[1]  = (acc == 4);
      settle();
      if (bus.s_axis_tvalid[1] && bus.s_axis_tready[1]) acc++;
      tick();
      c++;
    end
    if (acc < 2) fail_now("arst_setup");
    check("arst_pre_valid", 64'(bus.m_axis_tvalid), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", 64'(bus.m_axis_tvalid), 64'd0);
    check("arst_state", {55'd0, cur_grant, busy, bus.s_axis_tready}, 64'd0);
    idle_inputs();
    tick();
    rst = 1'b0;
    bus.s_axis_tvalid = 4'b1111;
    bus.s_axis_tlast  = 4'b1111;
    tick();
    check("arst_ptr", 64'(cur_grant), 64'b0001);
    idle_inputs();
    tick();

    // Randomised packets, lengths, mid-packet valid gaps and downstream stalls
    run_stream(6, 1'b1, "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
